// File: rtl/pc_fetch_pkg.sv
// Shared control encodings for the fetch stage: FSM states, reset PC, next-PC op codes.
package pc_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_TRAP   = 2'd3
    } npc_op_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request bus plus the fetch-to-decode handshake.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_misalign;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc, if_misalign,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc, if_misalign,
        output id_ready
    );
endinterface

// File: rtl/fetch_hold_reg.sv
// Holding register for one fetched entry (instruction, PC, misalign flag) with its valid bit.
module fetch_hold_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        misalign_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        misalign
);

    // Load wins over clear; the two never coincide since load only fires outside the hold state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= 32'h0;
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_in;
            pc       <= pc_in;
            misalign <= misalign_in;
        end else if (clear) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch FSM with PC and accepted-instruction counter.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_if.master        bus,
    output logic [31:0]       pc_out,
    input  logic [31:0]       npc_in,
    input  logic              halt,
    output logic [31:0]       fetch_cnt
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic        handshake;
    logic        misalign_trap;
    logic        hold_load;
    logic [31:0] hold_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_trap = (state == S_REQ) && (pc[1:0] != 2'b00);
`else
    assign misalign_trap = 1'b0;
`endif

    assign pc_out        = pc;
    assign bus.imem_req  = (state == S_REQ) && !misalign_trap;
    assign bus.imem_addr = word_align(pc);
    assign handshake     = bus.if_valid && bus.id_ready;
    assign hold_load     = ((state == S_WAIT) && bus.imem_rvalid) || misalign_trap;
    assign hold_instr    = misalign_trap ? 32'h0 : bus.imem_rdata;

    // rvalid is only looked at in S_WAIT, so a response to an abandoned request is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            fetch_cnt <= 32'h0;
        end else begin
            case (state)
                S_IDLE: if (!halt) state <= S_REQ;
                S_REQ: begin
                    if (misalign_trap)     state <= S_HOLD;
                    else if (bus.imem_gnt) state <= S_WAIT;
                end
                S_WAIT: if (bus.imem_rvalid) state <= S_HOLD;
                S_HOLD: begin
                    if (handshake) begin
                        pc        <= npc_in;
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= halt ? S_IDLE : S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fetch_hold_reg #(
        .RESET_PC (RESET_PC)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (hold_load),
        .clear       (handshake),
        .instr_in    (hold_instr),
        .pc_in       (pc),
        .misalign_in (misalign_trap),
        .valid       (bus.if_valid),
        .instr       (bus.if_instr),
        .pc          (bus.if_pc),
        .misalign    (bus.if_misalign)
    );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: per-cycle vector table plus reset-abandon and misalign sequences.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        halt;
    logic [31:0] fetch_cnt;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pc_out    (pc_out),
        .npc_in    (npc_in),
        .halt      (halt),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        halt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] npc;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt [23];
    int   total;
    int   passes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic [31:0] npc);
        halt            = h;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.id_ready    = rdy;
        npc_in          = npc;
    endtask

    initial begin
        total  = 0;
        passes = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //           halt gnt rv  rdata           rdy npc            req vld instr          ipc            pc             cnt
        vt[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0000_3000,32'h0000_3000,32'd0};
        vt[1]  = '{1'b0,1'b1,1'b1,32'hBAD0_BAD0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0000_3000,32'h0000_3000,32'd0};
        vt[2]  = '{1'b0,1'b0,1'b1,32'h2408_0001,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0000_3000,32'h0000_3000,32'd0};
        vt[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_3004,1'b0,1'b1,32'h2408_0001,32'h0000_3000,32'h0000_3000,32'd0};
        vt[4]  = '{1'b0,1'b0,1'b1,32'hBAD1_BAD1,1'b0,32'h0,        1'b1,1'b0,32'h2408_0001,32'h0000_3000,32'h0000_3004,32'd1};
        vt[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h2408_0001,32'h0000_3000,32'h0000_3004,32'd1};
        vt[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h2408_0001,32'h0000_3000,32'h0000_3004,32'd1};
        vt[7]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h2408_0001,32'h0000_3000,32'h0000_3004,32'd1};
        vt[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h2408_0001,32'h0000_3000,32'h0000_3004,32'd1};
        vt[9]  = '{1'b0,1'b0,1'b1,32'h00A0_0093,1'b0,32'h0,        1'b0,1'b0,32'h2408_0001,32'h0000_3000,32'h0000_3004,32'd1};
        for (int i = 10; i < 15; i++)
            vt[i] = '{1'b0,1'b0,1'b0,32'h0,     1'b0,32'h0000_9999,1'b0,1'b1,32'h00A0_0093,32'h0000_3004,32'h0000_3004,32'd1};
        vt[15] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0000_3010,1'b0,1'b1,32'h00A0_0093,32'h0000_3004,32'h0000_3004,32'd1};
        vt[16] = '{1'b1,1'b0,1'b1,32'hBAD2_BAD2,1'b0,32'h0,        1'b0,1'b0,32'h00A0_0093,32'h0000_3004,32'h0000_3010,32'd2};
        vt[17] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h00A0_0093,32'h0000_3004,32'h0000_3010,32'd2};
        vt[18] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h00A0_0093,32'h0000_3004,32'h0000_3010,32'd2};
        vt[19] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h00A0_0093,32'h0000_3004,32'h0000_3010,32'd2};
        vt[20] = '{1'b1,1'b0,1'b1,32'hDEAD_BEEF,1'b0,32'h0,        1'b0,1'b0,32'h00A0_0093,32'h0000_3004,32'h0000_3010,32'd2};
        vt[21] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0000_3014,1'b0,1'b1,32'hDEAD_BEEF,32'h0000_3010,32'h0000_3010,32'd2};
        vt[22] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'hDEAD_BEEF,32'h0000_3010,32'h0000_3014,32'd3};

        tick();
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].halt, vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].ready, vt[i].npc);
            chk($sformatf("v%0d_req", i),      {31'h0, bus.imem_req},    {31'h0, vt[i].e_req});
            chk($sformatf("v%0d_valid", i),    {31'h0, bus.if_valid},    {31'h0, vt[i].e_valid});
            chk($sformatf("v%0d_instr", i),    bus.if_instr,             vt[i].e_instr);
            chk($sformatf("v%0d_ifpc", i),     bus.if_pc,                vt[i].e_ipc);
            chk($sformatf("v%0d_pc", i),       pc_out,                   vt[i].e_pc);
            chk($sformatf("v%0d_cnt", i),      fetch_cnt,                vt[i].e_cnt);
            chk($sformatf("v%0d_misalign", i), {31'h0, bus.if_misalign}, 32'h0);
            if (vt[i].e_req)
                chk($sformatf("v%0d_addr", i), bus.imem_addr, {vt[i].e_pc[31:2], 2'b00});
            tick();
        end

        // Reset while waiting for data; the late response must be dropped.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("ra_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("ra_addr", bus.imem_addr, 32'h0000_3014);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("ra_wait_req", {31'h0, bus.imem_req}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'hBAD3_BAD3, 1'b0, 32'h0);
        chk("ra_req0",  {31'h0, bus.imem_req}, 32'h0);
        chk("ra_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("ra_pc",    pc_out, 32'h0000_3000);
        chk("ra_cnt",   fetch_cnt, 32'h0);
        chk("ra_ifpc",  bus.if_pc, 32'h0000_3000);
        chk("ra_instr", bus.if_instr, 32'h0);
        tick();
        chk("ra_valid2", {31'h0, bus.if_valid}, 32'h0);
        chk("ra_req2",   {31'h0, bus.imem_req}, 32'h1);
        chk("ra_addr2",  bus.imem_addr, 32'h0000_3000);
        tick();
        chk("ra_valid3", {31'h0, bus.if_valid}, 32'h0);
        chk("ra_req3",   {31'h0, bus.imem_req}, 32'h1);

        // Fetch once more, then hand back a misaligned next PC.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 32'h0);
        tick();
        chk("ma_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("ma_instr", bus.if_instr, 32'h1111_2222);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3006);
        tick();
        chk("ma_pc",  pc_out, 32'h0000_3006);
        chk("ma_cnt", fetch_cnt, 32'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ma_noreq", {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk("ma_trap_valid", {31'h0, bus.if_valid},    32'h1);
        chk("ma_trap_flag",  {31'h0, bus.if_misalign}, 32'h1);
        chk("ma_trap_instr", bus.if_instr, 32'h0);
        chk("ma_trap_ifpc",  bus.if_pc, 32'h0000_3006);
        chk("ma_trap_req",   {31'h0, bus.imem_req}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3008);
        tick();
        chk("ma_next_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("ma_next_addr", bus.imem_addr, 32'h0000_3008);
`else
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ma_req",      {31'h0, bus.imem_req}, 32'h1);
        chk("ma_addr",     bus.imem_addr, 32'h0000_3004);
        chk("ma_misalign", {31'h0, bus.if_misalign}, 32'h0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
